// File: rtl/muxnway_pkg.sv
// Shared constants for the N-way registered mux: mode encodings, output-stage
// states and the channel-index width helper.
package muxnway_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int sw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muxnway_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping at N-1.
// Purely combinational; ptr is the last granted channel.
module rr_arbiter
  import muxnway_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  int idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    // Walk from farthest to nearest so the nearest requester overwrites last.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[SW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/muxnway_rr.sv
// N-way mux into a one-word output register, fixed-select or round-robin.
// Optional MUXNWAY_RR_COUNT_EN adds a saturating 16-bit output handshake counter.
module muxnway_rr
  import muxnway_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int SW = sw_of(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
`ifdef MUXNWAY_RR_COUNT_EN
  output logic [15:0]    out_count,
`endif
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_chan
);

  state_t        state_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_chan_q;
  logic [SW-1:0] ptr_q;

  logic          load;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          fix_vld;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  assign load    = (state_q == ST_EMPTY) | out_ready;
  assign fix_vld = (int'(sel) < N) && in_valid[sel];
  assign gnt_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
  assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;

  always_comb begin
    in_ready = '0;
    if (!rst && load && gnt_vld) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q      <= SW'(N - 1);
    end else if (load) begin
      if (gnt_vld) begin
        state_q    <= ST_FULL;
        out_data_q <= in_data[gnt_idx*W +: W];
        out_chan_q <= gnt_idx;
        ptr_q      <= gnt_idx;
      end else begin
        state_q    <= ST_EMPTY;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = (state_q == ST_FULL);

`ifdef MUXNWAY_RR_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)                                             count_q <= '0;
    else if (out_valid && out_ready && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_muxnway_rr.sv
// Self-checking bench for muxnway_rr: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_muxnway_rr;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_chan;
`ifdef MUXNWAY_RR_COUNT_EN
  logic [15:0]    out_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit           m_full;
  logic [W-1:0] m_data;
  int           m_chan;
  int           m_ptr;
  int           m_count;

  always #5 clk = ~clk;

  muxnway_rr #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
`ifdef MUXNWAY_RR_COUNT_EN
    .out_count (out_count),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  // Which channel the rules say wins this cycle (ignoring load/reset).
  function automatic void model_grant(output bit g, output int idx);
    g   = 1'b0;
    idx = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin g = 1'b1; idx = int'(sel); end
    end else begin
      for (int k = 1; k <= N && !g; k++) begin
        if (in_valid[(m_ptr + k) % N]) begin g = 1'b1; idx = (m_ptr + k) % N; end
      end
    end
  endfunction

  function automatic logic [N-1:0] model_ready();
    bit g;
    int idx;
    logic [N-1:0] r;
    r = '0;
    model_grant(g, idx);
    if (!rst && (!m_full || out_ready) && g) r[idx] = 1'b1;
    return r;
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit g;
    int idx;
    @(posedge clk);
    model_grant(g, idx);
    if (rst) begin
      m_full = 0; m_data = '0; m_chan = 0; m_ptr = N - 1; m_count = 0;
    end else begin
      if (m_full && out_ready && m_count < 65535) m_count++;
      if (!m_full || out_ready) begin
        if (g) begin
          m_full = 1; m_data = in_data[idx*W +: W]; m_chan = idx; m_ptr = idx;
        end else begin
          m_full = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {16'h3333, 16'h2222, 16'h1111, 16'h0A0A};
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
        failures++; $display("FAIL reset_outputs got v=%b d=%h want v=0 d=0000", out_valid, out_data);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_rr got=%b want=0001", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 16'h0A0A) begin
      failures++; $display("FAIL reset_first_word got v=%b ch=%0d d=%h want v=1 ch=0 d=0a0a", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {$urandom, $urandom};
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_ready got=%b want=0100", in_ready); end
    tick();
    checks++;
    if (out_data !== in_data[2*W +: W] || out_chan !== 2'd2 || out_valid !== 1'b1) begin
      failures++; $display("FAIL fixed_word got d=%h ch=%0d want d=%h ch=2", out_data, out_chan, in_data[2*W +: W]);
    end
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL fixed_idle_ready got=%b want=0000", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_chan !== 2'd2) begin
      failures++; $display("FAIL fixed_drain got v=%b ch=%0d want v=0 ch=2", out_valid, out_chan);
    end
  endtask

  task automatic test_rr_all();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      in_data = {$urandom, $urandom};
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_chan) != exp_seq[c]) begin
        failures++; $display("FAIL rr_all[%0d] got v=%b ch=%0d want ch=%0d", c, out_valid, out_chan, exp_seq[c]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_seq[4] = '{1, 3, 1, 3};
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0) begin
        failures++; $display("FAIL rr_sparse_ready[%0d] got=%b want bits0,2 low", c, in_ready);
      end
      tick();
      checks++;
      if (int'(out_chan) != exp_seq[c]) begin
        failures++; $display("FAIL rr_sparse[%0d] got ch=%0d want ch=%0d", c, out_chan, exp_seq[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    in_data = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
    tick();
    in_valid = 4'b1111; out_ready = 1'b0;
    in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1234};
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b want=0000", c, in_ready); end
      mode = ~mode;  // mode flips must not disturb the held word
      tick();
      checks++;
      if (out_data !== 16'hBEEF || out_valid !== 1'b1 || out_chan !== 2'd0) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=beef", c, out_valid, out_data);
      end
    end
    mode = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL bp_release_ready got=%b want=0001", in_ready); end
    tick();
    checks++;
    if (out_data !== 16'h1234) begin failures++; $display("FAIL bp_next_word got=%h want=1234", out_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        failures++; $display("FAIL rand_ready[%0d] got=%b want=%b", c, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_full || (m_full && (out_data !== m_data || int'(out_chan) != m_chan))) begin
        failures++; $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                             c, out_valid, out_data, out_chan, m_full, m_data, m_chan);
      end
    end
    rst = 1'b0;
  endtask

`ifdef MUXNWAY_RR_COUNT_EN
  task automatic test_count();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (out_count !== 16'd5) begin failures++; $display("FAIL count_five got=%0d want=5", out_count); end
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_count !== 16'd5) begin failures++; $display("FAIL count_stall got=%0d want=5", out_count); end
  endtask
`endif

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0; in_data = '0;
    m_full = 0; m_data = '0; m_chan = 0; m_ptr = N - 1; m_count = 0;
    @(negedge clk);
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_random();
`ifdef MUXNWAY_RR_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
